// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and a legality helper for the BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register: load, step up/down with 9<->0 wrap, and limit flags.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] value,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t value_next;

    // Next digit value: load (illegal digits become 0) takes priority over stepping.
    always_comb begin
        value_next = value;
        if (load) begin
            value_next = is_bcd(load_value) ? load_value : BCD_MIN;
        end else if (step) begin
            if (up) begin
                value_next = (value >= BCD_MAX) ? BCD_MIN : value + 4'd1;
            end else begin
                value_next = (value == BCD_MIN) ? BCD_MAX : value - 4'd1;
            end
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= BCD_MIN;
        end else begin
            value <= value_next;
        end
    end

    assign at_max = (value == BCD_MAX);
    assign at_min = (value == BCD_MIN);

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit synchronous BCD up/down counter with lookahead carries and
// combinational terminal count for chaining.
// Optional parallel load compiled in when BCD_COUNTER_LOAD_EN is defined.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
`ifdef BCD_COUNTER_LOAD_EN
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    logic                  load_int;
    logic [4*DIGITS-1:0]   load_bus;
    logic                  count_en;
    logic [DIGITS-1:0]     step;
    logic [DIGITS-1:0]     at_max;
    logic [DIGITS-1:0]     at_min;
    logic                  all_max;
    logic                  all_min;

`ifdef BCD_COUNTER_LOAD_EN
    assign load_int = load;
    assign load_bus = load_value;
`else
    assign load_int = 1'b0;
    assign load_bus = '0;
`endif

    assign count_en = en & ~load_int;

    // Lookahead step enables: digit k steps when all lower digits sit at the limit for the direction.
    always_comb begin : step_chain
        logic carry;
        step  = '0;
        carry = count_en;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            step[k] = carry;
            carry   = carry & (up ? at_max[k] : at_min[k]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .step       (step[g]),
                .up         (up),
                .load       (load_int),
                .load_value (load_bus[4*g +: 4]),
                .value      (count[4*g +: 4]),
                .at_max     (at_max[g]),
                .at_min     (at_min[g])
            );
        end
    endgenerate

    assign all_max = &at_max;
    assign all_min = &at_min;
    assign tc      = en & (up ? all_max : all_min);

    // Wrap pulse: a counting edge with terminal count wraps every digit; loads never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc & ~load_int;
        end
    end

`ifdef BCD_COUNTER_LOAD_EN
    logic bad_digit;

    // Flag a load word containing any digit above 9.
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (!is_bcd(load_bus[4*k +: 4])) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Load error pulse, one cycle after the offending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load_int & bad_digit;
        end
    end
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter (DIGITS=2) plus a chained pair of DIGITS=1 instances.
// Load scenarios are exercised when BCD_COUNTER_LOAD_EN is defined.
module tb_bcd_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load_s = 1'b0;
    logic [7:0] load_value = '0;

    logic [7:0] count;
    logic       tc, wrap, load_err;

    logic [3:0] c0_count, c1_count;
    logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_err, c1_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain decimal value 0..99.
    int mval = 0;
    bit mvalid = 0;
    bit mwrap = 0;
    bit merr = 0;
    bit chain_chk = 0;

    always #5 clk = ~clk;

    bcd_counter #(.DIGITS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up         (up),
`ifdef BCD_COUNTER_LOAD_EN
        .load       (load_s),
        .load_value (load_value),
`endif
        .count      (count),
        .tc         (tc),
        .wrap       (wrap),
        .load_err   (load_err)
    );

    bcd_counter #(.DIGITS(1)) u_c0 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up         (up),
`ifdef BCD_COUNTER_LOAD_EN
        .load       (1'b0),
        .load_value (4'h0),
`endif
        .count      (c0_count),
        .tc         (c0_tc),
        .wrap       (c0_wrap),
        .load_err   (c0_err)
    );

    bcd_counter #(.DIGITS(1)) u_c1 (
        .clk        (clk),
        .reset      (reset),
        .en         (c0_tc),
        .up         (up),
`ifdef BCD_COUNTER_LOAD_EN
        .load       (1'b0),
        .load_value (4'h0),
`endif
        .count      (c1_count),
        .tc         (c1_tc),
        .wrap       (c1_wrap),
        .load_err   (c1_err)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic check1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One clock: drive inputs, check tc, step the model, check registered outputs.
    task automatic tick(input logic r, input logic l, input logic [7:0] lv,
                        input logic e, input logic u);
        bit eff_load;
        int d0, d1;
        reset = r; load_s = l; load_value = lv; en = e; up = u;
        #1;
        if (mvalid) check1("tc", tc, e && (u ? (mval == 99) : (mval == 0)));
        @(posedge clk);
        #1;
`ifdef BCD_COUNTER_LOAD_EN
        eff_load = l;
`else
        eff_load = 0;
`endif
        if (r) begin
            mval = 0; mwrap = 0; merr = 0; mvalid = 1;
        end else if (eff_load) begin
            d0 = int'(lv[3:0]);
            d1 = int'(lv[7:4]);
            merr = (d0 > 9) || (d1 > 9);
            if (d0 > 9) d0 = 0;
            if (d1 > 9) d1 = 0;
            mval = d1 * 10 + d0;
            mwrap = 0;
        end else if (e) begin
            if (u) begin
                mwrap = (mval == 99);
                mval = (mval + 1) % 100;
            end else begin
                mwrap = (mval == 0);
                mval = (mval + 99) % 100;
            end
            merr = 0;
        end else begin
            mwrap = 0;
            merr = 0;
        end
        if (mvalid) begin
            check8("count", count, to_bcd(mval));
            check1("wrap", wrap, mwrap);
            check1("load_err", load_err, merr);
            if (chain_chk) check8("chain_count", {c1_count, c0_count}, to_bcd(mval));
        end
    endtask

    typedef struct {
        logic       r;
        logic       l;
        logic [7:0] lv;
        logic       e;
        logic       u;
        logic [7:0] exp_count;
        logic       exp_wrap;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic l, input logic [7:0] lv, input logic e,
                           input logic u, input logic [7:0] c, input logic w, input logic le);
        vec_t v;
        v.r = r; v.l = l; v.lv = lv; v.e = e; v.u = u;
        v.exp_count = c; v.exp_wrap = w; v.exp_err = le;
        vecs.push_back(v);
    endtask

    initial begin
        // Directed table: {reset, load, load_value, en, up} -> {count, wrap, load_err}
        add_vec(1, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        add_vec(0, 0, 8'h00, 1, 1, 8'h01, 0, 0);
        add_vec(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        add_vec(0, 0, 8'h00, 1, 0, 8'h99, 1, 0);
        add_vec(0, 0, 8'h00, 1, 1, 8'h00, 1, 0);
        add_vec(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
`ifdef BCD_COUNTER_LOAD_EN
        add_vec(0, 1, 8'h3C, 1, 1, 8'h30, 0, 1);
        add_vec(0, 0, 8'h00, 0, 1, 8'h30, 0, 0);
        add_vec(0, 1, 8'h58, 1, 1, 8'h58, 0, 0);
        add_vec(0, 1, 8'h99, 1, 1, 8'h99, 0, 0);
        add_vec(0, 0, 8'h00, 1, 1, 8'h00, 1, 0);
        add_vec(0, 1, 8'hFA, 0, 0, 8'h00, 0, 1);
        add_vec(1, 1, 8'h77, 1, 1, 8'h00, 0, 0);
`endif

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            tick(vecs[i].r, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u);
            check8("tbl_count", count, vecs[i].exp_count);
            check1("tbl_wrap", wrap, vecs[i].exp_wrap);
            check1("tbl_load_err", load_err, vecs[i].exp_err);
        end

        // Full up count 00..99..00 with wrap only after 99->00
        tick(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 100; i++) tick(0, 0, 8'h00, 1, 1);
        check8("up100_count", count, 8'h00);
        check1("up100_wrap", wrap, 1'b1);

        // Down from 00: wrap to 99, then 10 more steps to 89
        tick(0, 0, 8'h00, 1, 0);
        check8("down_first", count, 8'h99);
        check1("down_wrap", wrap, 1'b1);
        for (int i = 0; i < 10; i++) tick(0, 0, 8'h00, 1, 0);
        check8("down_89", count, 8'h89);

        // Count to 47, hold 5 cycles, resume
        tick(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 47; i++) tick(0, 0, 8'h00, 1, 1);
        check8("at_47", count, 8'h47);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 8'h00, 0, 1);
            check8("hold_47", count, 8'h47);
            check1("hold_wrap", wrap, 1'b0);
            check1("hold_tc", tc, 1'b0);
        end
        tick(0, 0, 8'h00, 1, 1);
        check8("resume_48", count, 8'h48);

        // Reset wins over load and enable at 73
        tick(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 73; i++) tick(0, 0, 8'h00, 1, 1);
        check8("at_73", count, 8'h73);
        tick(1, 1, 8'h45, 1, 1);
        check8("rst_prio_count", count, 8'h00);
        check1("rst_prio_wrap", wrap, 1'b0);
        check1("rst_prio_err", load_err, 1'b0);

        // Chained DIGITS=1 pair against the model for 200 up-counting cycles
        tick(1, 0, 8'h00, 0, 1);
        chain_chk = 1;
        for (int i = 0; i < 200; i++) tick(0, 0, 8'h00, 1, 1);
        chain_chk = 0;

        // Randomised mix of reset, load, enable and direction
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
